uci_line_tx: RTL

- Parametrised multi-source UCI response serializer: next generation of the single-path info/bestmove output logic.
- Holds one zero-terminated message per source, arbitrates between sources and streams each message byte-by-byte onto the UART TX char stream, appending a line terminator.
- Adds per-source enable/drop, optional source-0 priority, round-robin fairness and a drop counter.

---
 rtl/uci_line_tx_if.sv | 30 +++
 rtl/uci_line_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uci_line_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uci_line_tx_if : message-source and TX char-stream bundle        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uci_line_tx_if #(
  parameter int NUM_SRC = 3,
  parameter int MSG_LEN = 64
);
  logic [NUM_SRC-1:0][MSG_LEN-1:0][7:0] msg_in;
  logic [NUM_SRC-1:0]                   msg_in_valid;
  logic [NUM_SRC-1:0]                   msg_in_ready;
  logic [NUM_SRC-1:0]                   src_enable_in;
  logic [7:0]                           char_out;
  logic                                 char_out_valid;
  logic                                 char_out_ready;
  logic                                 busy_out;
  logic [7:0]                           drop_count_out;

  modport master (
    output msg_in, msg_in_valid, src_enable_in, char_out_ready,
    input  msg_in_ready, char_out, char_out_valid, busy_out, drop_count_out
  );

  modport slave (
    input  msg_in, msg_in_valid, src_enable_in, char_out_ready,
    output msg_in_ready, char_out, char_out_valid, busy_out, drop_count_out
  );
endinterface
`default_nettype wire

// File: rtl/uci_line_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uci_line_tx : multi-source zero-terminated line serializer       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module uci_line_tx #(
  parameter int         NUM_SRC   = 3,
  parameter int         MSG_LEN   = 64,
  parameter int         PRIO0     = 1,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  uci_line_tx_if.slave bus
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IW = $clog2(MSG_LEN);

  typedef logic [MSG_LEN-1:0][7:0] msg_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2
  } state_t;

  state_t             state_q, state_d;
  msg_t               slot_q [NUM_SRC];
  msg_t               slot_d [NUM_SRC];
  logic [NUM_SRC-1:0] full_q, full_d;
  logic [SW-1:0]      grant_q, grant_d;
  logic [SW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         char_q, char_d;
  logic               valid_q, valid_d;
  logic [7:0]         drop_q, drop_d;

  logic               free_en;
  logic               hs;
  logic               found;
  logic [7:0]         cur_byte;
  logic [7:0]         nxt_byte;
  int                 cand;
  int                 drop_sum;

  assign hs       = valid_q && bus.char_out_ready;
  assign cur_byte = slot_q[grant_q][idx_q];
  assign nxt_byte = slot_q[grant_q][idx_q + IW'(1)];

  // Slot fill and drop accounting; the granted slot is freed on its terminator handshake.
  always_comb begin
    slot_d   = slot_q;
    full_d   = full_q;
    drop_sum = int'(drop_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.msg_in_valid[i] && !full_q[i]) begin
        if (bus.src_enable_in[i]) begin
          slot_d[i] = bus.msg_in[i];
          full_d[i] = 1'b1;
        end else begin
          drop_sum = drop_sum + 1;
        end
      end
    end
    if (free_en) begin
      full_d[grant_q] = 1'b0;
    end
    drop_d = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    char_d  = char_q;
    valid_d = valid_q;
    free_en = 1'b0;
    found   = 1'b0;
    cand    = 0;
    case (state_q)
      IDLE: begin
        if ((PRIO0 != 0) && full_q[0]) begin
          found   = 1'b1;
          grant_d = '0;
        end else begin
          // Search starts just past the last grant so every source gets its turn.
          for (int k = 1; k <= NUM_SRC; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_SRC) begin
              cand = cand - NUM_SRC;
            end
            if (!found && full_q[cand]) begin
              found   = 1'b1;
              grant_d = SW'(cand);
            end
          end
        end
        if (found) begin
          rr_d    = grant_d;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!valid_q) begin
          char_d  = (cur_byte == 8'h00) ? TERM_CHAR : cur_byte;
          valid_d = 1'b1;
          if (cur_byte == 8'h00) begin
            state_d = TERM;
          end
        end else if (hs) begin
          if ((idx_q == IW'(MSG_LEN - 1)) || (nxt_byte == 8'h00)) begin
            char_d  = TERM_CHAR;
            state_d = TERM;
          end else begin
            char_d = nxt_byte;
            idx_d  = idx_q + IW'(1);
          end
        end
      end
      TERM: begin
        if (hs) begin
          valid_d = 1'b0;
          free_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_q[i] <= '0;
      end
      full_q  <= '0;
      grant_q <= '0;
      rr_q    <= SW'(NUM_SRC - 1);
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_q[i] <= slot_d[i];
      end
      full_q  <= full_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.msg_in_ready   = ~full_q;
  assign bus.char_out       = char_q;
  assign bus.char_out_valid = valid_q;
  assign bus.busy_out       = (|full_q) || (state_q != IDLE);
  assign bus.drop_count_out = drop_q;

endmodule
`default_nettype wire
